// File: rtl/axis_prog_intra_cycle_delay.sv
// Runtime-programmable sample-granular AXIS delay: D = q*SPC + r as q whole-cycle stages plus an r-lane splice.
// Define AXIS_DELAY_STATS_EN to add the stat_frames / stat_cfg_loads counters.

module axis_delay_lane #(
  parameter int SPC          = 16,
  parameter int SAMPLE_WIDTH = 16,
  parameter int LANE         = 0,
  parameter int RW           = 4
) (
  input  logic [SPC-1:0][SAMPLE_WIDTH-1:0] cur_word,
  input  logic [SPC-1:0][SAMPLE_WIDTH-1:0] prev_word,
  input  logic [RW-1:0]                    r,
  output logic [SAMPLE_WIDTH-1:0]          sample
);
  logic [RW-1:0] cur_idx, prev_idx;

  // Lanes below r come from the tail of the older word.
  always_comb begin
    cur_idx  = RW'(LANE - int'(r));
    prev_idx = RW'(SPC + LANE - int'(r));
    sample   = (LANE >= int'(r)) ? cur_word[cur_idx] : prev_word[prev_idx];
  end
endmodule

module axis_prog_intra_cycle_delay #(
  parameter  int DATA_WIDTH      = 256,
  parameter  int SAMPLE_WIDTH    = 16,
  parameter  int MAX_CYCLE_DELAY = 8,
  parameter  int RESET_DELAY     = 10,
  localparam int SPC             = DATA_WIDTH / SAMPLE_WIDTH,
  localparam int DW              = $clog2((MAX_CYCLE_DELAY + 1) * SPC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic [DW-1:0]         cfg_delay,
  input  logic                  cfg_valid,
  output logic                  cfg_pending,
  output logic                  cfg_clamped,
  output logic [DW-1:0]         cur_delay
`ifdef AXIS_DELAY_STATS_EN
  ,
  output logic [31:0]           stat_frames,
  output logic [15:0]           stat_cfg_loads
`endif
);
  localparam int STAGES = MAX_CYCLE_DELAY + 1;
  localparam int QW     = $clog2(STAGES + 1);
  localparam int RW     = (SPC > 1) ? $clog2(SPC) : 1;
  localparam int MAX_D  = MAX_CYCLE_DELAY * SPC + SPC - 1;

  typedef logic [SPC-1:0][SAMPLE_WIDTH-1:0] word_t;
  typedef enum logic {CFG_IDLE, CFG_PENDING} cfg_state_t;

  logic [STAGES:0][SPC-1:0][SAMPLE_WIDTH-1:0] hist;
  logic [STAGES:0] vld_pipe, last_pipe;
  word_t           in_word, cur_word, prev_word, spliced;
  logic [QW-1:0]   q, q1;
  logic [RW-1:0]   r;

  assign in_word   = s_axis_tvalid ? word_t'(s_axis_tdata) : word_t'('0);
  assign q         = QW'(int'(cur_delay) / SPC);
  assign q1        = QW'(int'(q) + 1);
  assign r         = RW'(int'(cur_delay) % SPC);
  assign cur_word  = hist[q];
  assign prev_word = hist[q1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist      <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      hist      <= {hist[STAGES-1:0], in_word};
      vld_pipe  <= {vld_pipe[STAGES-1:0], s_axis_tvalid};
      last_pipe <= {last_pipe[STAGES-1:0], s_axis_tvalid & s_axis_tlast};
    end
  end

  for (genvar i = 0; i < SPC; i++) begin : g_lane
    axis_delay_lane #(
      .SPC(SPC), .SAMPLE_WIDTH(SAMPLE_WIDTH), .LANE(i), .RW(RW)
    ) u_lane (
      .cur_word(cur_word), .prev_word(prev_word), .r(r), .sample(spliced[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      m_axis_tdata  <= spliced;
      m_axis_tvalid <= vld_pipe[q] | ((r != '0) & vld_pipe[q1]);
      m_axis_tlast  <= (r == '0) ? last_pipe[q] : last_pipe[q1];
    end
  end

  // D may only change when no valid word is anywhere in the history or at the input.
  cfg_state_t    state;
  logic [DW-1:0] pend_delay, req_delay, load_val;
  logic          req_over, pipe_empty, do_load;

  assign req_over   = int'(cfg_delay) > MAX_D;
  assign req_delay  = req_over ? DW'(MAX_D) : cfg_delay;
  assign pipe_empty = ~|vld_pipe & ~s_axis_tvalid;
  assign do_load    = pipe_empty & (cfg_valid | (state == CFG_PENDING));
  assign load_val   = cfg_valid ? req_delay : pend_delay;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CFG_IDLE;
      cfg_pending <= 1'b0;
      cfg_clamped <= 1'b0;
      cur_delay   <= DW'(RESET_DELAY);
      pend_delay  <= '0;
    end else begin
      cfg_clamped <= cfg_valid & req_over;
      if (cfg_valid) pend_delay <= req_delay;
      if (do_load)   cur_delay  <= load_val;
      case (state)
        CFG_IDLE: if (cfg_valid && !pipe_empty) begin
          state       <= CFG_PENDING;
          cfg_pending <= 1'b1;
        end
        CFG_PENDING: if (pipe_empty) begin
          state       <= CFG_IDLE;
          cfg_pending <= 1'b0;
        end
        default: state <= CFG_IDLE;
      endcase
    end
  end

`ifdef AXIS_DELAY_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames    <= '0;
      stat_cfg_loads <= '0;
    end else begin
      if (m_axis_tvalid & m_axis_tlast) stat_frames    <= stat_frames + 32'd1;
      if (do_load)                      stat_cfg_loads <= stat_cfg_loads + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_axis_prog_intra_cycle_delay.sv
// Bench for axis_prog_intra_cycle_delay: sample-stream reference model plus directed literal checks.
module tb_axis_prog_intra_cycle_delay;
  localparam int DWID    = 256;
  localparam int SW      = 16;
  localparam int SPC     = DWID / SW;
  localparam int MAXC    = 8;
  localparam int RESET_D = 10;
  localparam int MAXD    = MAXC * SPC + SPC - 1;
  localparam int DW      = 8;
  localparam int HDEPTH  = MAXC + 2;
  localparam int NCYC    = 8192;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [DWID-1:0] s_tdata = '0;
  logic            s_tvalid = 1'b0, s_tlast = 1'b0;
  logic [DWID-1:0] m_tdata;
  logic            m_tvalid, m_tlast;
  logic [DW-1:0]   cfg_delay = '0;
  logic            cfg_valid = 1'b0;
  logic            cfg_pending, cfg_clamped;
  logic [DW-1:0]   cur_delay;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  axis_prog_intra_cycle_delay dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .cfg_delay(cfg_delay), .cfg_valid(cfg_valid),
    .cfg_pending(cfg_pending), .cfg_clamped(cfg_clamped), .cur_delay(cur_delay)
  );

  task automatic chk(string name, logic [DWID-1:0] act, logic [DWID-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Captured input words per cycle; words before the last reset are treated as absent.
  logic [DWID-1:0] in_d [NCYC];
  bit              in_v [NCYC];
  bit              in_l [NCYC];
  int cyc = 0, base = 0, m_d = RESET_D, m_pv = 0;
  bit m_pend = 0, m_clamp = 0;
  logic [SW-1:0] ramp = '0;

  function automatic int src_word(int idx);
    if (idx < 0) return -1;
    if (idx / SPC < base) return -1;
    return idx / SPC;
  endfunction

  // Output sample x of the flat stream equals input sample x - SPC - D (word-granular register offset).
  always @(posedge clk) begin : mon
    logic [DWID-1:0] e_d;
    bit e_v, e_l, empty, ov;
    int w, src, dprev, req;
    cyc++;
    if (cyc >= NCYC) begin
      $display("FAIL cycle_budget: got %0d expected <%0d", cyc, NCYC);
      $fatal(1);
    end
    if (!rst_n) begin
      base = cyc + 1; m_d = RESET_D; m_pend = 0; m_clamp = 0;
      #1;
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_cur_delay", cur_delay, RESET_D);
      chk("rst_pending", cfg_pending, 0);
    end else begin
      in_d[cyc] = s_tvalid ? s_tdata : '0;
      in_v[cyc] = s_tvalid;
      in_l[cyc] = s_tvalid & s_tlast;
      dprev = m_d;
      e_v = 0;
      for (int i = 0; i < SPC; i++) begin
        src = (cyc - 1) * SPC + i - dprev;
        w = src_word(src);
        e_d[i*SW +: SW] = (w < 0) ? '0 : in_d[w][(src % SPC)*SW +: SW];
        if (w >= 0 && in_v[w]) e_v = 1;
      end
      w = src_word((cyc - 1) * SPC - dprev);
      e_l = (w >= 0) && in_l[w];
      empty = !s_tvalid;
      for (int j = 1; j <= HDEPTH; j++)
        if (cyc - j >= base && in_v[cyc - j]) empty = 0;
      ov = cfg_valid && (int'(cfg_delay) > MAXD);
      req = ov ? MAXD : int'(cfg_delay);
      m_clamp = ov;
      if (empty && (cfg_valid || m_pend)) begin
        m_d = cfg_valid ? req : m_pv;
        m_pend = 0;
      end else if (cfg_valid) begin
        m_pend = 1;
        m_pv = req;
      end
      #1;
      chk("m_tdata", m_tdata, e_d);
      chk("m_tvalid", m_tvalid, e_v);
      chk("m_tlast", m_tlast, e_l);
      chk("cur_delay", cur_delay, m_d);
      chk("cfg_pending", cfg_pending, m_pend);
      chk("cfg_clamped", cfg_clamped, m_clamp);
    end
  end

  task automatic step(bit v, bit l, logic [DWID-1:0] d, bit cv, int cd);
    @(negedge clk);
    s_tvalid = v; s_tlast = l; s_tdata = d;
    cfg_valid = cv; cfg_delay = DW'(cd);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0);
  endtask

  task automatic set_delay(int d);
    idle(12);
    step(0, 0, '0, 1, d);
    idle(1);
  endtask

  function automatic logic [DWID-1:0] next_ramp();
    logic [DWID-1:0] wd;
    for (int i = 0; i < SPC; i++) begin
      wd[i*SW +: SW] = ramp;
      ramp++;
    end
    return wd;
  endfunction

  initial begin
    logic [DWID-1:0] wd, e0, e1, fw;
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // D=10 single word splice
    chk("t1_cur_delay", cur_delay, 10);
    e0 = '0; e1 = '0;
    for (int i = 0; i < SPC; i++) wd[i*SW +: SW] = SW'(i + 1);
    for (int i = 10; i < SPC; i++) e0[i*SW +: SW] = SW'(i - 9);
    for (int i = 0; i < 10; i++) e1[i*SW +: SW] = SW'(i + 7);
    step(1, 1, wd, 0, 0);
    idle(2);
    chk("t1_word0", m_tdata, e0);
    chk("t1_word0_vld", m_tvalid, 1);
    chk("t1_word0_last", m_tlast, 0);
    idle(1);
    chk("t1_word1", m_tdata, e1);
    chk("t1_word1_last", m_tlast, 1);
    idle(1);
    chk("t1_after_vld", m_tvalid, 0);

    // D=0 random burst
    set_delay(0);
    chk("t2_cur_delay", cur_delay, 0);
    fw = '0;
    for (int i = 0; i < 100; i++) begin
      wd = {8{$urandom}};
      if (i == 0) fw = wd;
      step(1, i == 99, wd, 0, 0);
      if (i == 2) chk("t2_latency2", m_tdata, fw);
    end

    // D=35 ramp with gaps
    set_delay(35);
    chk("t3_cur_delay", cur_delay, 35);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0 || i == 59) step(1, i == 59, next_ramp(), 0, 0);
      else step(0, 0, '0, 0, 0);
    end

    // mid-frame reconfiguration, last write wins
    set_delay(35);
    for (int i = 0; i < 40; i++) begin
      step(1, i == 39, next_ramp(), i == 10 || i == 20, (i == 10) ? 7 : 5);
      if (i == 11) begin
        chk("t4_pending", cfg_pending, 1);
        chk("t4_hold_delay", cur_delay, 35);
      end
    end
    step(0, 0, '0, 0, 0);
    n = 0;
    while (cfg_pending && n < 60) begin
      step(0, 0, '0, 0, 0);
      n++;
    end
    chk("t4_drain", cfg_pending, 0);
    chk("t4_cur_delay", cur_delay, 5);
    for (int i = 0; i < 30; i++) step(1, i == 29, next_ramp(), 0, 0);

    // clamp
    idle(12);
    step(0, 0, '0, 1, MAXD + 1);
    idle(1);
    chk("t5_cur_delay", cur_delay, MAXD);
    chk("t5_clamped", cfg_clamped, 1);
    idle(1);
    chk("t5_clamp_pulse", cfg_clamped, 0);

    // reset mid-burst
    for (int i = 0; i < 20; i++) begin
      step(1, 0, next_ramp(), 0, 0);
      if (i == 15) begin
        chk("t6_pre_vld", m_tvalid, 1);
        rst_n = 1'b0; s_tvalid = 1'b0;
        #1;
        chk("t6_rst_vld", m_tvalid, 0);
        chk("t6_rst_delay", cur_delay, RESET_D);
        break;
      end
    end
    idle(3);
    rst_n = 1'b1;
    chk("t6_cur_delay", cur_delay, RESET_D);
    for (int i = 0; i < 10; i++) step(1, i == 9, next_ramp(), 0, 0);

    // randomized bursts with random reconfiguration
    for (int b = 0; b < 60; b++) begin
      n = $urandom_range(1, 30);
      for (int i = 0; i < n; i++)
        step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, {8{$urandom}},
             $urandom_range(0, 9) == 0, $urandom_range(0, 160));
      n = $urandom_range(0, 14);
      for (int i = 0; i < n; i++)
        step(0, 0, '0, $urandom_range(0, 9) == 0, $urandom_range(0, 160));
    end
    idle(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
